// File: rtl/ed2platform_cpu_debug_slave_cmdq.sv
// Debug-slave command queue: synchronizes scan-domain update-DR/IR strobes into clk,
// queues {ir, sr} per update-DR event in a first-word-fall-through FIFO.
module ed2platform_cpu_debug_slave_cmdq #(
  parameter int unsigned SR_W        = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       cmd_ready,
  input  logic                       clr_overflow,
  output logic                       cmd_valid,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            cmd_data,
  output logic [(1<<IR_W)-1:0]       cmd_onehot,
  output logic [SR_W-1:0]            jdo,
  output logic                       ir_update_pulse,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = IR_W + SR_W;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_hist, uir_hist;
  logic                   udr_evt_c, uir_evt_c;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt_c;
  logic          pop_c, full_c, drop_c, wr_en_c;

  // Event = synchronized level high while the history flop still holds the old low
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_hist <= 1'b0;
      uir_hist <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist <= udr_sync[SYNC_STAGES-1];
      uir_hist <= uir_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    udr_evt_c   = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    uir_evt_c   = uir_sync[SYNC_STAGES-1] & ~uir_hist;
    pop_c       = cmd_valid & cmd_ready;
    full_c      = (level == LW'(DEPTH));
    drop_c      = udr_evt_c & full_c & ~pop_c;
    wr_en_c     = udr_evt_c & ~drop_c;
    level_nxt_c = level;
    case ({wr_en_c, pop_c})
      2'b10:   level_nxt_c = level + LW'(1);
      2'b01:   level_nxt_c = level - LW'(1);
      default: level_nxt_c = level;
    endcase
  end

  // Storage array carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      cmd_valid       <= 1'b0;
      overflow        <= 1'b0;
      jdo             <= '0;
      ir_update_pulse <= 1'b0;
    end else begin
      level           <= level_nxt_c;
      cmd_valid       <= (level_nxt_c != '0);
      ir_update_pulse <= uir_evt_c;
      if (wr_en_c)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      if (udr_evt_c) jdo    <= sr;
      // A drop in the same cycle as a clear keeps the flag set
      if (drop_c)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_comb begin
    {cmd_ir, cmd_data} = mem[rd_ptr];
    cmd_onehot         = '0;
    if (cmd_valid) cmd_onehot[cmd_ir] = 1'b1;
  end

endmodule

// File: tb/tb_ed2platform_cpu_debug_slave_cmdq.sv
// Scoreboard bench for the debug command queue: directed scenarios followed by random traffic.
module tb_ed2platform_cpu_debug_slave_cmdq;

  localparam int unsigned SR_W  = 38;
  localparam int unsigned IR_W  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  vs_udr = 1'b0, vs_uir = 1'b0;
  logic [IR_W-1:0]       ir_in = '0;
  logic [SR_W-1:0]       sr = '0;
  logic                  cmd_ready = 1'b0, clr_overflow = 1'b0;
  logic                  cmd_valid, ir_update_pulse, overflow;
  logic [IR_W-1:0]       cmd_ir;
  logic [SR_W-1:0]       cmd_data, jdo;
  logic [(1<<IR_W)-1:0]  cmd_onehot;
  logic [$clog2(DEPTH):0] level;

  ed2platform_cpu_debug_slave_cmdq #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .clr_overflow(clr_overflow), .cmd_valid(cmd_valid),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_onehot(cmd_onehot), .jdo(jdo),
    .ir_update_pulse(ir_update_pulse), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an input level first seen high at edge k enqueues at edge k+SYNC
  // using the ir/sr present at that edge; samples at or before a reset edge count as low.
  bit            uh [SYNC+2];
  bit            ih [SYNC+2];
  int            mlevel = 0;
  bit            mov = 1'b0, mpulse = 1'b0;
  logic [SR_W-1:0] mjdo = '0;
  typedef struct { logic [IR_W-1:0] ir; logic [SR_W-1:0] data; } entry_t;
  entry_t        sb [$];

  always @(posedge clk) begin
    if (reset) begin
      foreach (uh[i]) begin uh[i] = 1'b0; ih[i] = 1'b0; end
      mlevel = 0; mov = 1'b0; mpulse = 1'b0; mjdo = '0;
      sb.delete();
    end else begin
      bit ue, ie, pop, push;
      for (int i = SYNC + 1; i > 0; i--) begin uh[i] = uh[i-1]; ih[i] = ih[i-1]; end
      uh[0] = vs_udr;
      ih[0] = vs_uir;
      ue = uh[SYNC] && !uh[SYNC+1];
      ie = ih[SYNC] && !ih[SYNC+1];
      pop  = (mlevel > 0) && cmd_ready;
      push = ue;
      mpulse = ie;
      if (ue) mjdo = sr;
      if (push && mlevel == DEPTH && !pop) begin
        mov = 1'b1;
        push = 1'b0;
      end else if (clr_overflow) begin
        mov = 1'b0;
      end
      if (pop) mlevel--;
      if (push) begin
        entry_t e;
        e.ir = ir_in; e.data = sr;
        sb.push_back(e);
        mlevel++;
      end
    end
  end

  // Monitor: state compared every cycle, head entry compared whenever the DUT pops
  always @(negedge clk) begin
    if (run && !reset) begin
      chk("level", 64'(level), 64'(mlevel));
      chk("cmd_valid", 64'(cmd_valid), 64'(mlevel > 0));
      chk("overflow", 64'(overflow), 64'(mov));
      chk("jdo", 64'(jdo), 64'(mjdo));
      chk("ir_update_pulse", 64'(ir_update_pulse), 64'(mpulse));
      if (!cmd_valid) chk("onehot_idle", 64'(cmd_onehot), 64'(0));
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          chk("pop_nonempty_sb", 64'(1), 64'(0));
        end else begin
          logic [(1<<IR_W)-1:0] oh;
          oh = '0;
          oh[sb[0].ir] = 1'b1;
          chk("cmd_ir", 64'(cmd_ir), 64'(sb[0].ir));
          chk("cmd_data", 64'(cmd_data), 64'(sb[0].data));
          chk("cmd_onehot", 64'(cmd_onehot), 64'(oh));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One udr (optionally uir) pulse; rdy/clr are asserted only at the enqueue edge
  task automatic pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                       input bit uir, input bit rdy_p, input bit clr_p);
    vs_udr = 1'b1; vs_uir = uir; ir_in = ir; sr = d;
    repeat (SYNC) cyc();
    cmd_ready = rdy_p; clr_overflow = clr_p;
    cyc();
    cmd_ready = 1'b0; clr_overflow = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0;
    cyc();
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    cmd_ready = 1'b0;
  endtask

  initial begin
    #1;
    repeat (3) cyc();
    chk("reset_level", 64'(level), 64'(0));
    chk("reset_valid", 64'(cmd_valid), 64'(0));
    chk("reset_jdo", 64'(jdo), 64'(0));
    reset = 1'b0;
    run = 1'b1;
    cyc();

    // Basic event and latency
    vs_udr = 1'b1; ir_in = 2'd2; sr = 38'h12_3456_789A;
    cyc();
    repeat (SYNC - 1) cyc();
    chk("latency_not_yet", 64'(cmd_valid), 64'(0));
    cyc();
    chk("latency_valid", 64'(cmd_valid), 64'(1));
    chk("first_onehot", 64'(cmd_onehot), 64'(4'b0100));
    chk("first_jdo", 64'(jdo), 64'(38'h12_3456_789A));
    repeat (3) cyc();
    chk("held_high_single", 64'(level), 64'(1));
    vs_udr = 1'b0;
    cyc();
    drain();

    // Five events with no consumer: fifth dropped
    for (int i = 0; i < 5; i++)
      pulse(IR_W'(i), SR_W'(38'h100 + i), 1'b0, 1'b0, 1'b0);
    cyc();
    chk("full_level", 64'(level), 64'(DEPTH));
    chk("full_overflow", 64'(overflow), 64'(1));
    chk("full_jdo", 64'(jdo), 64'(38'h104));
    drain();
    clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
    chk("clr_alone", 64'(overflow), 64'(0));

    // Full queue with pop at the enqueue edge
    for (int i = 0; i < 4; i++)
      pulse(IR_W'(i), SR_W'(38'h200 + i), 1'b0, 1'b0, 1'b0);
    pulse(2'd3, 38'h2FF, 1'b0, 1'b1, 1'b0);
    chk("push_pop_full_level", 64'(level), 64'(DEPTH));
    chk("push_pop_full_ovf", 64'(overflow), 64'(0));
    drain();

    // Simultaneous udr and uir
    pulse(2'd1, 38'h3_0000_0001, 1'b1, 1'b0, 1'b0);
    chk("simul_level", 64'(level), 64'(1));
    drain();

    // Drop coinciding with clear keeps overflow set
    for (int i = 0; i < 4; i++)
      pulse(IR_W'(i), SR_W'(38'h400 + i), 1'b0, 1'b0, 1'b0);
    pulse(2'd0, 38'h4FF, 1'b0, 1'b0, 1'b1);
    chk("drop_beats_clr", 64'(overflow), 64'(1));

    // Reset with entries queued
    drain();
    for (int i = 0; i < 3; i++)
      pulse(IR_W'(i), SR_W'(38'h500 + i), 1'b0, 1'b0, 1'b0);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midreset_level", 64'(level), 64'(0));
    chk("midreset_valid", 64'(cmd_valid), 64'(0));
    chk("midreset_jdo", 64'(jdo), 64'(0));

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bit busy_phase;
      busy_phase = ((n / 300) % 2) == 1;
      if ($urandom_range(0, 2) == 0) begin
        vs_udr = ~vs_udr;
        if (vs_udr) begin
          ir_in = IR_W'($urandom());
          sr    = SR_W'({$urandom(), $urandom()});
        end
      end
      if ($urandom_range(0, 4) == 0) vs_uir = ~vs_uir;
      cmd_ready    = busy_phase ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; clr_overflow = 1'b0;
    repeat (SYNC + 3) cyc();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
